// File: rtl/io_uart_tx_pkg.sv
// Shared definitions for the IO-bus UART transmitter: register offsets, status
// bit layout and FSM state encodings.
package io_uart_tx_pkg;

  localparam logic [7:0] UART_DATA   = 8'h08;
  localparam logic [7:0] UART_STATUS = 8'h10;

  localparam int ST_FULL   = 0;
  localparam int ST_EMPTY  = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_ACTIVE = 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Field order gives bit3..bit0 = tx_active, overflow, empty, full.
  typedef struct packed {
    logic active;
    logic ovf;
    logic empty;
    logic full;
  } status_t;

  function automatic logic [31:0] pack_status(status_t s);
    return {28'd0, s};
  endfunction

endpackage

// File: rtl/io_uart_tx_if.sv
// Core IO store/load port as seen by the UART responder.
// Handshake: no valid/ready pair; IO_mem_wr is a one-cycle write strobe that is
// always accepted, and IO_mem_rdata is valid combinationally whenever io_sel/addr are.
interface io_uart_tx_if;
  logic        io_sel;
  logic [31:0] IO_mem_addr;
  logic [31:0] IO_mem_wdata;
  logic        IO_mem_wr;
  logic [31:0] IO_mem_rdata;

  modport master (
    output io_sel,
    output IO_mem_addr,
    output IO_mem_wdata,
    output IO_mem_wr,
    input  IO_mem_rdata
  );

  modport slave (
    input  io_sel,
    input  IO_mem_addr,
    input  IO_mem_wdata,
    input  IO_mem_wr,
    output IO_mem_rdata
  );
endinterface

// File: rtl/io_uart_tx_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read; the caller only pushes
// when the entry can be accepted and only pops when non-empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A push while full with a pop overwrites the slot being read this cycle,
  // which is safe because the popped word is taken from rdata before the edge.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, sticky overflow flag, TX FIFO
// and the baud-timed serialiser FSM.
module io_uart_tx
  import io_uart_tx_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 27000000,
  parameter int BAUD        = 115200,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic             clk,
  input  logic             resetn,
  io_uart_tx_if.slave      bus,
  output logic             tx,
  output logic             tx_busy,
  output logic [1:0]       fsm_state
);

  localparam int DIV = CLK_FREQ_HZ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

  logic [1:0]    state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          ovf;

  logic          fifo_full;
  logic          fifo_empty;
  logic [7:0]    fifo_rdata;
  logic          wr_data;
  logic          wr_stat;
  logic          rd_stat;
  logic          baud_done;
  logic          pop;
  logic          push;
  logic          ovf_set;
  logic          ovf_clr;
  status_t       status;

  assign wr_data = bus.io_sel && bus.IO_mem_wr && (|(bus.IO_mem_addr[7:0] & UART_DATA));
  assign wr_stat = bus.io_sel && bus.IO_mem_wr && (|(bus.IO_mem_addr[7:0] & UART_STATUS));
  assign rd_stat = bus.io_sel && (|(bus.IO_mem_addr[7:0] & UART_STATUS));

  assign baud_done = (baud_cnt == '0);
  assign pop       = !fifo_empty && ((state == S_IDLE) || (state == S_STOP && baud_done));
  assign push      = wr_data && (!fifo_full || pop);
  assign ovf_set   = wr_data && fifo_full && !pop;
  assign ovf_clr   = wr_stat && bus.IO_mem_wdata[ST_OVF];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .wdata  (bus.IO_mem_wdata[7:0]),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Set has priority so a dropped byte is never hidden by a concurrent clear.
  always_ff @(posedge clk) begin
    if (!resetn)      ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  // tx is updated on the same edge as the state change, so each line level
  // lasts exactly DIV cycles and a frame is 10*DIV cycles.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shreg    <= fifo_rdata;
            baud_cnt <= DIV_M1;
            tx       <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (baud_done) begin
            baud_cnt <= DIV_M1;
            bit_cnt  <= '0;
            tx       <= shreg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= DIV_M1;
            if (bit_cnt == 3'd7) begin
              tx    <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        S_STOP: begin
          if (baud_done) begin
            if (pop) begin
              shreg    <= fifo_rdata;
              baud_cnt <= DIV_M1;
              tx       <= 1'b0;
              state    <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    status        = '0;
    status.full   = fifo_full;
    status.empty  = fifo_empty;
    status.ovf    = ovf;
    status.active = (state != S_IDLE);
  end

  assign bus.IO_mem_rdata = rd_stat ? pack_status(status) : 32'd0;
  assign tx_busy          = status.active || !fifo_empty;
  assign fsm_state        = state;

  // Address and data bits outside the decoded fields are intentionally ignored.
  logic unused_bus_bits;
  assign unused_bus_bits = &{1'b0, bus.IO_mem_addr[31:8], bus.IO_mem_addr[2:0],
                             bus.IO_mem_wdata[31:8]};

endmodule
